// File: rtl/ps2_host_fifo_if.sv
// Front-end bus for ps2_host_fifo.
// Carries the command (TX) handshake, the receive FIFO pop handshake and the status outputs.
// Modports:
//   master - keyboard/mouse front-end: drives tx_data/tx_valid, rx_ready and clear_errors
//   slave  - the PS/2 host: drives tx_ready, the completion pulses, the FIFO head and status
interface ps2_host_fifo_if #(
    parameter int unsigned RX_DEPTH = 16
);
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       tx_done;
    logic                       tx_error;
    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic [$clog2(RX_DEPTH):0]  rx_count;
    logic                       rx_frame_err;
    logic                       rx_overflow;
    logic                       clear_errors;
    logic                       init_busy;

    modport master (
        output tx_data, tx_valid, rx_ready, clear_errors,
        input  tx_ready, tx_done, tx_error, rx_data, rx_valid, rx_count,
        input  rx_frame_err, rx_overflow, init_busy
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, clear_errors,
        output tx_ready, tx_done, tx_error, rx_data, rx_valid, rx_count,
        output rx_frame_err, rx_overflow, init_busy
    );
endinterface

// File: rtl/ps2_host_fifo.sv
// PS/2 host transceiver with a show-ahead receive FIFO and a retrying transmit path.
// Ports:
//   CLOCK_50  in     system clock, rising edge
//   reset     in     synchronous active-high reset
//   PS2_CLK   inout  open-drain clock line (driven 0 or released)
//   PS2_DAT   inout  open-drain data line (driven 0 or released)
//   bus       slave  command handshake, FIFO pop handshake and status (see ps2_host_fifo_if)
module ps2_host_fifo #(
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned MAX_RETRY      = 2,
    parameter bit          INIT_EN        = 1'b0,
    parameter logic [7:0]  INIT_CMD       = 8'hF4
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    inout  wire            PS2_CLK,
    inout  wire            PS2_DAT,
    ps2_host_fifo_if.slave bus
);
    localparam int unsigned AW       = $clog2(RX_DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned TimerMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                         : INHIBIT_CYCLES;
    localparam int unsigned TW       = $clog2(TimerMax + 1);
    localparam int unsigned AttW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]   TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   InhibitLast = TW'(INHIBIT_CYCLES - 1);
    localparam logic [AttW-1:0] RetryMax    = AttW'(MAX_RETRY);
    localparam logic [CW-1:0]   DepthVal    = CW'(RX_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StRx, StTxInhibit, StTxStart, StTxBits, StTxAck, StTxRelease
    } state_e;

    // Line synchronisers; prev stage gives the falling-edge detect.
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      rx_shift_q, rx_shift_d;
    logic [8:0]      tx_frame_q, tx_frame_d;   // {parity, data}
    logic [AttW-1:0] attempt_q, attempt_d;
    logic            cur_init_q, cur_init_d;
    logic            init_busy_q, init_busy_d;
    logic            clk_low_q, clk_low_d;
    logic            dat_low_q, dat_low_d;
    logic            wr_en_q, wr_en_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            frame_err_q, frame_err_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_error_q, tx_error_d;

    logic [7:0]      mem_q [RX_DEPTH];
    logic [7:0]      mem_d [RX_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic fall, rx_start, tx_ready, tx_accept, tx_fail;
    logic rx_valid, pop, full, push;

    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    assign fall      = clk_prev_q && !clk_sync_q;
    assign rx_start  = fall && !dat_sync_q;
    // Hidden while a start bit is seen so an accepted command is never lost to RX priority.
    assign tx_ready  = (state_q == StIdle) && !init_busy_q && !reset && !rx_start;
    assign tx_accept = bus.tx_valid && tx_ready;

    // ---------------- Line FSM ----------------
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_frame_d  = tx_frame_q;
        attempt_d   = attempt_q;
        cur_init_d  = cur_init_q;
        init_busy_d = init_busy_q;
        clk_low_d   = clk_low_q;
        dat_low_d   = dat_low_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        tx_done_d   = 1'b0;
        tx_error_d  = 1'b0;
        tx_fail     = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d   = '0;
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (rx_start) begin
                    state_d   = StRx;
                    bit_cnt_d = '0;
                end else if (init_busy_q) begin
                    tx_frame_d = {~^INIT_CMD, INIT_CMD};
                    cur_init_d = 1'b1;
                    attempt_d  = '0;
                    clk_low_d  = 1'b1;
                    state_d    = StTxInhibit;
                end else if (tx_accept) begin
                    tx_frame_d = {~^bus.tx_data, bus.tx_data};
                    cur_init_d = 1'b0;
                    attempt_d  = '0;
                    clk_low_d  = 1'b1;
                    state_d    = StTxInhibit;
                end
            end
            StRx: begin
                if (fall) begin
                    timer_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        // Shift holds d0..d7 and parity; current data is the stop bit.
                        wr_en_d     = (^rx_shift_q) && dat_sync_q;
                        frame_err_d = !((^rx_shift_q) && dat_sync_q);
                        wr_data_d   = rx_shift_q[7:0];
                        state_d     = StIdle;
                    end else begin
                        rx_shift_d = {dat_sync_q, rx_shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end else if (timer_q == TimeoutLast) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StTxInhibit: begin
                clk_low_d = 1'b1;
                dat_low_d = 1'b0;
                if (timer_q == InhibitLast) begin
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b1;
                    timer_d   = '0;
                    state_d   = StTxStart;
                end
            end
            StTxStart: begin
                if (fall) begin
                    dat_low_d = ~tx_frame_q[0];
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = StTxBits;
                end else if (timer_q == TimeoutLast) begin
                    tx_fail = 1'b1;
                end
            end
            StTxBits: begin
                if (fall) begin
                    timer_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        dat_low_d = 1'b0;   // stop bit: release
                        state_d   = StTxAck;
                    end else begin
                        dat_low_d = ~tx_frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timer_q == TimeoutLast) begin
                    tx_fail = 1'b1;
                end
            end
            StTxAck: begin
                if (fall) begin
                    timer_d = '0;
                    if (!dat_sync_q) begin
                        state_d = StTxRelease;
                    end else begin
                        tx_fail = 1'b1;
                    end
                end else if (timer_q == TimeoutLast) begin
                    tx_fail = 1'b1;
                end
            end
            StTxRelease: begin
                if (clk_sync_q && dat_sync_q) begin
                    tx_done_d = !cur_init_q;
                    if (cur_init_q) begin
                        init_busy_d = 1'b0;
                    end
                    state_d = StIdle;
                end else if (timer_q == TimeoutLast) begin
                    tx_fail = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tx_fail) begin
            dat_low_d = 1'b0;
            timer_d   = '0;
            if (attempt_q < RetryMax) begin
                attempt_d = attempt_q + AttW'(1);
                clk_low_d = 1'b1;
                state_d   = StTxInhibit;
            end else begin
                clk_low_d  = 1'b0;
                tx_error_d = !cur_init_q;
                if (cur_init_q) begin
                    init_busy_d = 1'b0;
                end
                state_d = StIdle;
            end
        end
    end

    // ---------------- Receive FIFO ----------------
    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid && bus.rx_ready;
    assign full     = (count_q == DepthVal);
    assign push     = wr_en_q && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        // A same-cycle overflow outranks clear_errors.
        if (bus.clear_errors) begin
            overflow_d = 1'b0;
        end
        if (wr_en_q && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_frame_q  <= '0;
            attempt_q   <= '0;
            cur_init_q  <= 1'b0;
            init_busy_q <= INIT_EN;
            clk_low_q   <= 1'b0;
            dat_low_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_error_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_meta_q  <= PS2_CLK;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            dat_meta_q  <= PS2_DAT;
            dat_sync_q  <= dat_meta_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_frame_q  <= tx_frame_d;
            attempt_q   <= attempt_d;
            cur_init_q  <= cur_init_d;
            init_busy_q <= init_busy_d;
            clk_low_q   <= clk_low_d;
            dat_low_q   <= dat_low_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            tx_done_q   <= tx_done_d;
            tx_error_q  <= tx_error_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.tx_ready     = tx_ready;
    assign bus.tx_done      = tx_done_q;
    assign bus.tx_error     = tx_error_q;
    assign bus.rx_data      = mem_q[rd_ptr_q];
    assign bus.rx_valid     = rx_valid;
    assign bus.rx_count     = count_q;
    assign bus.rx_frame_err = frame_err_q;
    assign bus.rx_overflow  = overflow_q;
    assign bus.init_busy    = init_busy_q;
endmodule

// File: tb/tb_ps2_host_fifo.sv
// Bench for ps2_host_fifo: instance 0 is a plain host, instance 1 sends INIT_CMD after reset.
// A behavioural PS/2 device drives each pair of open-drain lines.
module tb_ps2_host_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    wire  ps2_clk0, ps2_dat0, ps2_clk1, ps2_dat1;
    pullup (ps2_clk0);
    pullup (ps2_dat0);
    pullup (ps2_clk1);
    pullup (ps2_dat1);

    logic dev_clk_low [2];
    logic dev_dat_low [2];
    assign ps2_clk0 = dev_clk_low[0] ? 1'b0 : 1'bz;
    assign ps2_dat0 = dev_dat_low[0] ? 1'b0 : 1'bz;
    assign ps2_clk1 = dev_clk_low[1] ? 1'b0 : 1'bz;
    assign ps2_dat1 = dev_dat_low[1] ? 1'b0 : 1'bz;

    ps2_host_fifo_if #(.RX_DEPTH(16)) bus0 ();
    ps2_host_fifo_if #(.RX_DEPTH(16)) bus1 ();

    ps2_host_fifo #(
        .RX_DEPTH(16), .INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(2000), .MAX_RETRY(2),
        .INIT_EN(1'b0), .INIT_CMD(8'hF4)
    ) u_dut0 (
        .CLOCK_50(clk), .reset(rst0), .PS2_CLK(ps2_clk0), .PS2_DAT(ps2_dat0), .bus(bus0)
    );

    ps2_host_fifo #(
        .RX_DEPTH(16), .INHIBIT_CYCLES(40), .TIMEOUT_CYCLES(2000), .MAX_RETRY(2),
        .INIT_EN(1'b1), .INIT_CMD(8'hF4)
    ) u_dut1 (
        .CLOCK_50(clk), .reset(rst1), .PS2_CLK(ps2_clk1), .PS2_DAT(ps2_dat1), .bus(bus1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse and host-inhibit monitors.
    int   n_ferr [2];
    int   n_done [2];
    int   n_err  [2];
    int   n_inh;
    logic inh_prev;
    initial begin
        n_ferr[0] = 0; n_ferr[1] = 0;
        n_done[0] = 0; n_done[1] = 0;
        n_err[0]  = 0; n_err[1]  = 0;
        n_inh     = 0;
        inh_prev  = 1'b0;
    end
    always @(negedge clk) begin
        if (bus0.rx_frame_err === 1'b1) n_ferr[0] <= n_ferr[0] + 1;
        if (bus1.rx_frame_err === 1'b1) n_ferr[1] <= n_ferr[1] + 1;
        if (bus0.tx_done === 1'b1)      n_done[0] <= n_done[0] + 1;
        if (bus1.tx_done === 1'b1)      n_done[1] <= n_done[1] + 1;
        if (bus0.tx_error === 1'b1)     n_err[0]  <= n_err[0] + 1;
        if (bus1.tx_error === 1'b1)     n_err[1]  <= n_err[1] + 1;
        inh_prev <= (ps2_clk0 === 1'b0) && !dev_clk_low[0];
        if ((ps2_clk0 === 1'b0) && !dev_clk_low[0] && !inh_prev) n_inh <= n_inh + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic line(input int d, input bit dat);
        if (d == 0) return dat ? ps2_dat0 : ps2_clk0;
        return dat ? ps2_dat1 : ps2_clk1;
    endfunction

    task automatic wait_line(input int d, input bit dat, input logic val, input int budget,
                             input string tag, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (line(d, dat) !== val) begin
            if (n >= budget) begin
                check(tag, {31'd0, line(d, dat)}, {31'd0, val});
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Device-to-host frame: start, d0..d7, parity, stop; only the first nbits are sent.
    task automatic dev_send(input int d, input logic [7:0] data, input logic par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low[d] = ~frame[i];
            wait_cycles(5);
            dev_clk_low[d] = 1'b1;
            wait_cycles(10);
            dev_clk_low[d] = 1'b0;
            wait_cycles(5);
        end
        dev_dat_low[d] = 1'b0;
        wait_cycles(10);
    endtask

    // Host-to-device frame: measures the inhibit, clocks out 10 bits, then ACKs or NACKs.
    task automatic dev_host_rx(input int d, input bit ack, output logic [9:0] bits,
                               output int inh_len);
        bit ok;
        bits    = '0;
        inh_len = 0;
        wait_line(d, 1'b0, 1'b0, 20000, "inhibit_seen", ok);
        if (!ok) return;
        while (line(d, 1'b0) === 1'b0 && inh_len < 20000) begin
            @(negedge clk);
            inh_len++;
        end
        check("start_bit", {31'd0, line(d, 1'b1)}, 32'd0);
        wait_cycles(5);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low[d] = 1'b1;
            wait_cycles(10);
            bits[i] = line(d, 1'b1);
            dev_clk_low[d] = 1'b0;
            wait_cycles(10);
        end
        if (ack) dev_dat_low[d] = 1'b1;
        wait_cycles(5);
        dev_clk_low[d] = 1'b1;
        wait_cycles(10);
        dev_clk_low[d] = 1'b0;
        wait_cycles(5);
        dev_dat_low[d] = 1'b0;
        wait_cycles(5);
    endtask

    task automatic pop0();
        bus0.rx_ready = 1'b1;
        @(negedge clk);
        bus0.rx_ready = 1'b0;
    endtask

    logic [9:0] bits;
    int         inh_len;
    int         base;

    initial begin
        dev_clk_low[0] = 1'b0; dev_dat_low[0] = 1'b0;
        dev_clk_low[1] = 1'b0; dev_dat_low[1] = 1'b0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.tx_data = 8'h00; bus0.tx_valid = 1'b0; bus0.rx_ready = 1'b0;
        bus0.clear_errors = 1'b0;
        bus1.tx_data = 8'h00; bus1.tx_valid = 1'b0; bus1.rx_ready = 1'b0;
        bus1.clear_errors = 1'b0;

        // Reset state.
        wait_cycles(3);
        check("rst_tx_ready", {31'd0, bus0.tx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, bus0.rx_valid}, 32'd0);
        check("rst_rx_count", {27'd0, bus0.rx_count}, 32'd0);
        check("rst_overflow", {31'd0, bus0.rx_overflow}, 32'd0);
        rst0 = 1'b0;
        wait_cycles(2);
        check("idle_tx_ready", {31'd0, bus0.tx_ready}, 32'd1);
        check("idle_init_busy", {31'd0, bus0.init_busy}, 32'd0);
        check("idle_lines", {30'd0, ps2_clk0, ps2_dat0}, 32'd3);

        // 1) Good byte 0xAA.
        dev_send(0, 8'hAA, 1'b1, 11);
        check("t1_rx_data", {24'd0, bus0.rx_data}, 32'hAA);
        check("t1_rx_valid", {31'd0, bus0.rx_valid}, 32'd1);
        check("t1_rx_count", {27'd0, bus0.rx_count}, 32'd1);
        check("t1_no_ferr", n_ferr[0], 0);
        pop0();
        wait_cycles(1);
        check("t1_pop_empty", {27'd0, bus0.rx_count}, 32'd0);

        // 2) Bad parity 0x55.
        dev_send(0, 8'h55, 1'b0, 11);
        check("t2_ferr_once", n_ferr[0], 1);
        check("t2_rx_count", {27'd0, bus0.rx_count}, 32'd0);

        // 3) Overflow: 17 bytes into 16 entries.
        for (int i = 0; i < 17; i++) begin
            dev_send(0, 8'(i), ~^(8'(i)), 11);
        end
        check("t3_rx_count", {27'd0, bus0.rx_count}, 32'd16);
        check("t3_overflow", {31'd0, bus0.rx_overflow}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t3_pop_data", {24'd0, bus0.rx_data}, i);
            pop0();
        end
        check("t3_drained", {31'd0, bus0.rx_valid}, 32'd0);
        bus0.clear_errors = 1'b1;
        @(negedge clk);
        bus0.clear_errors = 1'b0;
        check("t3_cleared", {31'd0, bus0.rx_overflow}, 32'd0);

        // 4) Send 0xED, device ACKs, then replies 0xFA.
        n_inh = 0;
        base  = n_done[0];
        bus0.tx_data  = 8'hED;
        bus0.tx_valid = 1'b1;
        @(negedge clk);
        bus0.tx_valid = 1'b0;
        check("t4_ready_drop", {31'd0, bus0.tx_ready}, 32'd0);
        dev_host_rx(0, 1'b1, bits, inh_len);
        wait_cycles(10);
        check("t4_inhibit_len", inh_len, 5000);
        check("t4_data_bits", {24'd0, bits[7:0]}, 32'hED);
        check("t4_parity", {31'd0, bits[8]}, 32'd1);
        check("t4_stop", {31'd0, bits[9]}, 32'd1);
        check("t4_done_once", n_done[0] - base, 1);
        check("t4_ready_back", {31'd0, bus0.tx_ready}, 32'd1);
        dev_send(0, 8'hFA, 1'b1, 11);
        check("t4_reply", {24'd0, bus0.rx_data}, 32'hFA);
        pop0();

        // 5) Device NACKs every attempt.
        n_inh = 0;
        base  = n_done[0];
        bus0.tx_data  = 8'h12;
        bus0.tx_valid = 1'b1;
        @(negedge clk);
        bus0.tx_valid = 1'b0;
        for (int a = 0; a < 3; a++) begin
            dev_host_rx(0, 1'b0, bits, inh_len);
        end
        wait_cycles(20);
        check("t5_inhibits", n_inh, 3);
        check("t5_error_once", n_err[0], 1);
        check("t5_no_done", n_done[0] - base, 0);
        check("t5_ready_back", {31'd0, bus0.tx_ready}, 32'd1);

        // 6) Init command from instance 1.
        check("t6_rst_ready", {31'd0, bus1.tx_ready}, 32'd0);
        check("t6_rst_busy", {31'd0, bus1.init_busy}, 32'd1);
        rst1 = 1'b0;
        @(negedge clk);
        check("t6_ready_low", {31'd0, bus1.tx_ready}, 32'd0);
        dev_host_rx(1, 1'b1, bits, inh_len);
        wait_cycles(10);
        check("t6_init_byte", {24'd0, bits[7:0]}, 32'hF4);
        check("t6_init_parity", {31'd0, bits[8]}, 32'd0);
        check("t6_inhibit_len", inh_len, 40);
        check("t6_busy_clear", {31'd0, bus1.init_busy}, 32'd0);
        check("t6_ready_high", {31'd0, bus1.tx_ready}, 32'd1);
        check("t6_no_done", n_done[1], 0);

        // Reset while receiving, after data bit 3.
        dev_send(1, 8'h3C, 1'b1, 5);
        rst1 = 1'b1;
        wait_cycles(2);
        check("t6_rst_lines", {30'd0, ps2_clk1, ps2_dat1}, 32'd3);
        check("t6_rst_count", {27'd0, bus1.rx_count}, 32'd0);
        rst1 = 1'b0;
        wait_cycles(5);
        check("t6_no_ferr", n_ferr[1], 0);
        check("t6_no_err", n_err[1], 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
